// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register word offsets,
// CTRL/STATUS bit positions and the FSM state type.
package timer_pkg;

    // Register selects are word offsets, i.e. address[4:2].
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_WIDTH   = 3;

    localparam int unsigned STAT_MATCH   = 0;
    localparam int unsigned STAT_RUNNING = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: while enabled, emits a one-cycle tick every prescale+1 cycles.
// A clear restarts the period from zero.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == prescale);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + PRESC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_slave.sv
// Memory-map timer slave: prescaled up-counter with compare match, periodic or
// one-shot operation, sticky MATCH flag and level interrupt.
module timer_slave
    import timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    logic [2:0]             reg_sel;
    logic                   unused_addr;
    logic                   wr_ctrl, wr_presc, wr_compare, wr_count, wr_status;
    logic                   tick, hit, oneshot_hit;
    logic                   running, presc_clear, restart;

    state_e                 state_q, state_d;
    logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [DATA_WIDTH-1:0]  compare_q, compare_d;
    logic [DATA_WIDTH-1:0]  count_q, count_d;
    logic                   match_q, match_d;

    assign reg_sel     = address[4:2];
    assign unused_addr = ^{address[31:5], address[1:0]};

    assign wr_ctrl    = we && (reg_sel == REG_CTRL);
    assign wr_presc   = we && (reg_sel == REG_PRESCALE);
    assign wr_compare = we && (reg_sel == REG_COMPARE);
    assign wr_count   = we && (reg_sel == REG_COUNT);
    assign wr_status  = we && (reg_sel == REG_STATUS);

    // A COUNT write suppresses match evaluation on a coincident tick.
    assign hit         = tick && !wr_count && (count_q == compare_q);
    assign oneshot_hit = hit && ctrl_q[CTRL_ONESHOT];

    timer_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (running),
        .clear   (presc_clear),
        .prescale(presc_q),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (wr_ctrl && wd[CTRL_EN]) state_d = ST_RUN;
            ST_RUN: begin
                if (oneshot_hit) begin
                    state_d = ST_HALT;
                end else if (wr_ctrl && !wd[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: if (wr_ctrl && wd[CTRL_EN]) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running     = (state_q == ST_RUN);
        restart     = (state_q == ST_HALT) && (state_d == ST_RUN);
        presc_clear = ((state_q != ST_RUN) && (state_d == ST_RUN)) || wr_presc || wr_count;
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        compare_d = compare_q;
        count_d   = count_q;
        match_d   = match_q;

        if (wr_ctrl)    ctrl_d    = wd[CTRL_WIDTH-1:0];
        if (oneshot_hit) ctrl_d[CTRL_EN] = 1'b0;
        if (wr_presc)   presc_d   = wd[PRESC_WIDTH-1:0];
        if (wr_compare) compare_d = wd;

        if (wr_count) begin
            count_d = wd;
        end else if (restart) begin
            count_d = '0;
        end else if (hit) begin
            if (!ctrl_q[CTRL_ONESHOT]) count_d = '0;
        end else if (tick) begin
            count_d = count_q + DATA_WIDTH'(1);
        end

        // Hardware set wins over a coincident write-1-to-clear.
        if (wr_status && wd[STAT_MATCH]) match_d = 1'b0;
        if (hit)                         match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            compare_q <= '1;
            count_q   <= '0;
            match_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        rd = '0;
        if (re) begin
            unique case (reg_sel)
                REG_CTRL:     rd = DATA_WIDTH'(ctrl_q);
                REG_PRESCALE: rd = DATA_WIDTH'(presc_q);
                REG_COMPARE:  rd = compare_q;
                REG_COUNT:    rd = count_q;
                REG_STATUS: begin
                    rd[STAT_MATCH]   = match_q;
                    rd[STAT_RUNNING] = running;
                end
                default:      rd = '0;
            endcase
        end
    end

    assign irq = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_slave.sv
// Bench for timer_slave: directed scenarios plus randomized bus traffic, with
// read expectations queued at issue time and checked by a separate monitor.
module tb_timer_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] address = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rd;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [2:0]  off;
        logic [31:0] val;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    timer_slave #(
        .DATA_WIDTH (32),
        .PRESC_WIDTH(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wd     (wd),
        .address(address),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .irq    (irq)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural reference: timer described by its mode, register values and
    // the number of cycles spent counting since the last prescaler restart.
    localparam int M_STOPPED  = 0;
    localparam int M_COUNTING = 1;
    localparam int M_HALTED   = 2;

    logic [2:0]  m_ctrl  = '0;
    logic [15:0] m_presc = '0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic [31:0] m_count = '0;
    logic        m_match = 1'b0;
    int          m_mode  = M_STOPPED;
    int unsigned m_age   = 0;

    task automatic model_reset();
        m_ctrl  = '0;
        m_presc = '0;
        m_cmp   = 32'hFFFF_FFFF;
        m_count = '0;
        m_match = 1'b0;
        m_mode  = M_STOPPED;
        m_age   = 0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [2:0] sel;
        bit wr_c, wr_p, wr_k, wr_n, wr_s, tick, hit, oneshot, start, stop, was_counting;
        sel     = a[4:2];
        wr_c    = w && (sel == 3'd0);
        wr_p    = w && (sel == 3'd1);
        wr_k    = w && (sel == 3'd2);
        wr_n    = w && (sel == 3'd3);
        wr_s    = w && (sel == 3'd4);
        was_counting = (m_mode == M_COUNTING);
        tick    = was_counting && ((m_age % (32'(m_presc) + 1)) == 32'(m_presc));
        hit     = tick && !wr_n && (m_count == m_cmp);
        oneshot = m_ctrl[1];
        start   = wr_c && d[0] && !was_counting;
        stop    = wr_c && !d[0] && was_counting && !(hit && oneshot);

        if (wr_n)                              m_count = d;
        else if (start && m_mode == M_HALTED)  m_count = '0;
        else if (hit)                          m_count = oneshot ? m_count : 32'd0;
        else if (tick)                         m_count = m_count + 32'd1;

        if (wr_p) m_presc = d[15:0];
        if (wr_k) m_cmp   = d;
        if (wr_c) m_ctrl  = d[2:0];

        if (hit && oneshot) begin
            m_ctrl[0] = 1'b0;
            m_mode    = M_HALTED;
        end else if (start) begin
            m_mode = M_COUNTING;
        end else if (stop) begin
            m_mode = M_STOPPED;
        end

        if (wr_s && d[0]) m_match = 1'b0;
        if (hit)          m_match = 1'b1;

        if (start || wr_p || wr_n) m_age = 0;
        else if (was_counting)     m_age = m_age + 1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [2:0] sel;
        sel = a[4:2];
        case (sel)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return {16'd0, m_presc};
            3'd2:    return m_cmp;
            3'd3:    return m_count;
            3'd4:    return {30'd0, (m_mode == M_COUNTING), m_match};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(we, address, wd);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: consumes one queued expectation for every cycle the DUT is read.
    always @(negedge clk) begin
        rd_exp_t e;
        if (re) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", rd, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd_off%0d", e.off), rd, e.val);
            end
        end else begin
            check("rd_idle", rd, 32'd0);
        end
        check("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
    end

    function automatic logic [31:0] mk_addr(input logic [2:0] off);
        logic [31:0] r;
        r = $urandom();
        return {r[31:5], off, r[1:0]};
    endfunction

    task automatic cycle_drive(input logic w, input logic r, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] e);
        rd_exp_t x;
        we      = w;
        re      = r;
        address = a;
        wd      = d;
        if (r) begin
            x.off = a[4:2];
            x.val = e;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle_drive(1'b0, 1'b0, $urandom(), $urandom(), 32'd0);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        cycle_drive(1'b1, 1'b0, mk_addr(off), d, 32'd0);
    endtask

    task automatic rdx(input logic [2:0] off, input logic [31:0] e);
        cycle_drive(1'b0, 1'b1, mk_addr(off), $urandom(), e);
    endtask

    task automatic wait_irq(input int unsigned max, output int unsigned at);
        at = 0;
        for (int unsigned i = 0; i < max; i++) begin
            idle();
            if (irq === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned en_cyc, at1, at2, op;
        logic [31:0] d, a;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("reset_irq", {31'd0, irq}, 32'd0);
        rdx(3'd0, 32'd0);
        rdx(3'd1, 32'd0);
        rdx(3'd2, 32'hFFFF_FFFF);
        rdx(3'd3, 32'd0);
        rdx(3'd4, 32'd0);
        rdx(3'd5, 32'd0);
        rdx(3'd6, 32'd0);
        rdx(3'd7, 32'd0);
        idle();

        // Periodic: PRESCALE=1, COMPARE=3 -> match every 8 cycles
        wr(3'd1, 32'd1);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h5);
        en_cyc = cyc;
        wait_irq(30, at1);
        check("periodic_first_match", at1 - en_cyc, 32'd8);
        rdx(3'd3, 32'd0);
        wr(3'd4, 32'd1);
        check("periodic_w1c_irq", {31'd0, irq}, 32'd0);
        wait_irq(30, at2);
        check("periodic_period", at2 - at1, 32'd8);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);

        // One-shot: PRESCALE=0, COMPARE=5
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h3);
        repeat (5) idle();
        rdx(3'd4, 32'd2);
        rdx(3'd4, 32'd1);
        rdx(3'd0, 32'd2);
        rdx(3'd3, 32'd5);
        repeat (3) idle();
        rdx(3'd3, 32'd5);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'h3);
        rdx(3'd3, 32'd0);
        rdx(3'd3, 32'd1);
        wr(3'd0, 32'd0);

        // Collision: W1C on the same edge as a match
        wr(3'd4, 32'd1);
        wr(3'd2, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd0, 32'h5);
        idle();
        wr(3'd4, 32'd1);
        rdx(3'd4, 32'd3);
        check("collision_irq", {31'd0, irq}, 32'd1);
        wr(3'd0, 32'd0);
        wr(3'd4, 32'd1);
        rdx(3'd4, 32'd0);

        // COUNT write near the top of the range, then wrap
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd0, 32'h5);
        wr(3'd3, 32'hFFFF_FFFE);
        rdx(3'd4, 32'd2);
        rdx(3'd3, 32'hFFFF_FFFF);
        rdx(3'd3, 32'd0);
        rdx(3'd4, 32'd3);
        idle();
        check("preasync_irq", {31'd0, irq}, 32'd1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1 check("async_irq", {31'd0, irq}, 32'd0);
        rdx(3'd0, 32'd0);
        rdx(3'd2, 32'hFFFF_FFFF);
        rdx(3'd3, 32'd0);
        rdx(3'd4, 32'd0);
        idle();
        #2 rst_n = 1'b1;
        repeat (10) idle();
        rdx(3'd3, 32'd0);
        rdx(3'd4, 32'd0);
        rdx(3'd0, 32'd0);

        // Randomized traffic against the reference model
        for (int unsigned i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 99);
            d  = $urandom();
            if (op < 30) begin
                idle();
            end else if (op < 55) begin
                a = mk_addr(3'($urandom_range(0, 7)));
                cycle_drive(1'b0, 1'b1, a, d, model_read(a));
            end else if (op < 65) begin
                d[0] = ($urandom_range(0, 9) < 7);
                wr(3'd0, d);
            end else if (op < 73) begin
                wr(3'd4, d);
            end else if (op < 81) begin
                if ($urandom_range(0, 3) != 0) d = m_cmp - 32'($urandom_range(0, 3));
                wr(3'd3, d);
            end else if (op < 87) begin
                if ($urandom_range(0, 7) != 0) d = 32'($urandom_range(0, 12));
                wr(3'd2, d);
            end else if (op < 93) begin
                d[15:0] = 16'($urandom_range(0, 3));
                wr(3'd1, d);
            end else if (op < 97) begin
                wr(3'($urandom_range(5, 7)), d);
            end else begin
                a = mk_addr(3'($urandom_range(0, 7)));
                cycle_drive(1'b1, 1'b1, a, d, model_read(a));
            end
        end

        idle();
        idle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
